io_uart_rx: RTL and testbench
=============================

# io_uart_rx

Serial receive front-end that sits directly upstream of `user_proj_example`. It takes one raw pad bit from `io_in` and recovers 8N1 UART frames using 16× oversampling. Bytes are buffered in a small FIFO and presented to the core over a valid/ready stream. The pad-side outputs (`rx_oeb_o`) are driven so the wrapper can wire the pin straight into the `io_oeb` bus.

## Interface
- `CLKS_PER_TICK`, default 14: `wb_clk_i` cycles per oversample tick (25 MHz / (115200×16) ≈ 14). Legal range 1..65535.
- `FIFO_DEPTH`, default 8: receive FIFO entries. Must be a power of two, ≥2.
- `wb_clk_i`, in, 1: single clock for the whole block.
- `wb_rst_i`, in, 1: reset, synchronous and active-high; the only reset.
- `rx_i`, in, 1: raw serial line from `io_in[n]`; idle level 1; asynchronous to `wb_clk_i`.
- `rx_oeb_o`, out, 1: pad output-enable-bar; constant 1 (pad is input).
- `m_data_o`, out, 8: received byte at FIFO head.
- `m_valid_o`, out, 1: FIFO non-empty.
- `m_ready_i`, in, 1: consumer accepts the head byte when `m_valid_o && m_ready_i`.
- `frame_err_o`, out, 1: one-cycle pulse when a stop bit samples 0.
- `overrun_o`, out, 1: one-cycle pulse when a good byte is dropped because the FIFO is full.
- `fifo_count_o`, out, $clog2(FIFO_DEPTH)+1: current occupancy.

## Operation
- **Synchronizer.** `rx_i` passes through a 2-flop synchronizer, reset to 1. All logic uses the synchronized bit `rx_s`.
- **Tick generator.** A counter runs from 0 to CLKS_PER_TICK−1 and emits `tick` on wrap. It is held at 0 in IDLE, so each frame is phase-aligned to its start edge.
- **Bit timing.** A 4-bit tick counter `tcnt` and a 3-bit index `bidx` time the bits.
- **FSM states** (shared enum): IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: when `rx_s` is 0, go to START and clear `tcnt`.
  - START: on the 8th tick (mid-bit), if `rx_s`=0 go to DATA (`tcnt`=0, `bidx`=0). If `rx_s`=1 it is a false start: return to IDLE with no output.
  - DATA: every 16th tick, shift `rx_s` into the shift register LSB-first. After `bidx`=7 is sampled, go to STOP.
  - STOP: on the 16th tick, sample `rx_s`.
    - If 1: push the byte and go to IDLE.
    - If 0: pulse `frame_err_o`, discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE: stay until `rx_s`=1, then go to IDLE. A break condition therefore yields exactly one `frame_err_o`.
- **FIFO.** Circular buffer with pointers one bit wider than the index.
  - Push when full: byte dropped, `overrun_o` pulses, FIFO contents unchanged. This holds even if a pop occurs in the same cycle, because fullness is judged before the pop.
  - Push and pop in the same cycle while not full and not empty: count unchanged, both take effect.
  - Pop when empty: ignored.
- **Output stability.** `m_data_o` always shows the head entry. It holds stable while `m_valid_o`=1 and `m_ready_i`=0.

## Timing
- **Reset values:**
  - `m_valid_o`=0, `m_data_o`=0, `frame_err_o`=0, `overrun_o`=0, `fifo_count_o`=0, `rx_oeb_o`=1.
  - FSM=IDLE; synchronizer flops=1; pointers=0.
- **Reset mid-frame.** Any partially received byte is discarded and the FIFO is emptied. After reset releases, the next falling edge starts a new frame.
- **Start detection.** `rx_i` falling edge to START entry: 2 cycles (synchronizer) + 1.
- **Push to valid.** A push in cycle N (stop-bit sample) gives `m_valid_o`=1 and a valid `m_data_o` in cycle N+1 (registered FIFO write).
- **Pulses.** `frame_err_o` and `overrun_o` are registered and assert in the cycle after the stop-bit sample.
- **Pop.** A handshake in cycle N advances the head, so the new `m_data_o`/`m_valid_o` appear in N+1. Sustained throughput is 1 byte/cycle on the read side.
- **Frame length.** 10 bits × 16 ticks × CLKS_PER_TICK cycles, nominally. The STOP → IDLE return happens at stop-bit mid-sample, which gives a half-bit margin for back-to-back frames.

## Structure
- **Package `io_uart_pkg`:**
  - `rx_state_t` enum (IDLE, START, DATA, STOP, WAIT_IDLE).
  - Constants `OVERSAMPLE`=16, `MID_TICK`=8, `DATA_BITS`=8.
- **Sub-module `io_sync_fifo`** (parameters WIDTH, DEPTH):
  - push/pop, full/empty, count outputs.
  - Reused later for the TX path.
- **Top-level contents:** synchronizer, tick generator, FSM and shift register.

## Test plan
- **Single byte.** Reset, then drive 0xA5 at CLKS_PER_TICK=4 with `m_ready_i`=0 → `m_valid_o`=1, `m_data_o`=0xA5, `fifo_count_o`=1, no error pulses.
- **False start.** Pulse `rx_i` low for 20 cycles (less than half a bit at CLKS_PER_TICK=4, i.e. <32 cycles) → FSM returns to IDLE, `m_valid_o` stays 0.
- **Framing error.** Send 0x3C with stop bit = 0 and hold the line low for 3 bit-times → exactly one `frame_err_o` pulse, no push. A following byte 0x81 is received correctly.
- **Overrun.** With `m_ready_i`=0, send bytes 0x00..0x08 (9 bytes, FIFO_DEPTH=8) → `fifo_count_o`=8, one `overrun_o` pulse on the 9th byte. Draining yields 0x00..0x07 in order.
- **Back-pressure and streaming.** Send 0x11, 0x22, 0x33 back-to-back while toggling `m_ready_i` every cycle → bytes delivered in order, and `m_data_o` is stable whenever `m_valid_o`=1 and `m_ready_i`=0.
- **Reset mid-frame.** Assert `wb_rst_i` for 1 cycle after data bit 3 of 0xFF → all outputs return to reset values. A subsequent 0x5A is received intact.

Source files
------------

// File: rtl/io_uart_pkg.sv
// -----------------------------------------------------------------------------
// io_uart_pkg
// Types and constants shared by the UART receive front-end and the FIFO
// that buffers its bytes.
//   rx_state_t : receiver FSM states
//   OVERSAMPLE : ticks per serial bit
//   MID_TICK   : tick count that places the start-bit sample mid-bit
//   DATA_BITS  : data bits per frame (8N1)
// -----------------------------------------------------------------------------
package io_uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } rx_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int MID_TICK   = 8;
    localparam int DATA_BITS  = 8;

endpackage : io_uart_pkg

// File: rtl/io_sync_fifo.sv
// -----------------------------------------------------------------------------
// io_sync_fifo
// Single-clock circular-buffer FIFO. The pointers carry one extra wrap bit, so
// full and empty are told apart without a separate flag.
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_push, i_data      : write request and data (ignored while full)
//   i_pop               : read request (ignored while empty)
//   o_data              : head entry, 0 while empty
//   o_full, o_empty     : occupancy flags
//   o_count             : number of stored entries
// -----------------------------------------------------------------------------
module io_sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [AW:0]      o_count
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [AW:0]      w_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign w_count   = r_wr_ptr - r_rd_ptr;
    assign o_count   = w_count;
    assign o_full    = (w_count == FULL_CNT);
    assign o_empty   = (w_count == '0);

    // Fullness is judged before any same-cycle pop, so a push into a full
    // FIFO is always dropped.
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop  && !o_empty;

    // Masking the head while empty keeps the output at 0 after reset even
    // though the storage itself is never cleared.
    assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its inputs, whatever the statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // NOTE: the storage array has no reset; the pointers alone define which
    // entries are valid, and leaving it unreset lets it map onto plain RAM.
    always_ff @(posedge i_clk) begin
        if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule : io_sync_fifo

// File: rtl/io_uart_rx.sv
// -----------------------------------------------------------------------------
// io_uart_rx
// 8N1 UART receiver with 16x oversampling, feeding a small FIFO presented as a
// valid/ready byte stream.
//   wb_clk_i, wb_rst_i  : clock, synchronous active-high reset
//   rx_i                : raw serial line (idle 1, asynchronous)
//   rx_oeb_o            : pad output-enable-bar, tied 1 (input pad)
//   m_data_o, m_valid_o : FIFO head byte and non-empty flag
//   m_ready_i           : consumer accepts head when valid && ready
//   frame_err_o         : one-cycle pulse, stop bit sampled as 0
//   overrun_o           : one-cycle pulse, good byte dropped on full FIFO
//   fifo_count_o        : FIFO occupancy
// -----------------------------------------------------------------------------
module io_uart_rx
    import io_uart_pkg::*;
#(
    parameter int CLKS_PER_TICK = 14,
    parameter int FIFO_DEPTH    = 8
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_i,
    input  logic                          rx_i,
    output logic                          rx_oeb_o,
    output logic [7:0]                    m_data_o,
    output logic                          m_valid_o,
    input  logic                          m_ready_i,
    output logic                          frame_err_o,
    output logic                          overrun_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

    localparam logic [15:0] TICK_MAX  = 16'(CLKS_PER_TICK - 1);
    localparam logic [3:0]  TCNT_MID  = 4'(MID_TICK - 1);
    localparam logic [3:0]  TCNT_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [2:0]  BIDX_LAST = 3'(DATA_BITS - 1);

    logic [1:0]  r_sync;
    logic        w_rx_s;
    logic [15:0] r_clk_cnt;
    logic        w_tick;

    rx_state_t   r_state, w_state_nxt;
    logic [3:0]  r_tcnt,  w_tcnt_nxt;
    logic [2:0]  r_bidx,  w_bidx_nxt;
    logic [7:0]  r_shift, w_shift_nxt;
    logic        w_push;
    logic        w_stop_bad;

    logic        r_frame_err;
    logic        r_overrun;
    logic        w_fifo_full;
    logic        w_fifo_empty;

    assign rx_oeb_o    = 1'b1;
    assign frame_err_o = r_frame_err;
    assign overrun_o   = r_overrun;
    assign m_valid_o   = !w_fifo_empty;

    // Two-flop synchronizer; reset to the idle line level so reset release
    // can never look like a start edge.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) r_sync <= 2'b11;
        else          r_sync <= {r_sync[0], rx_i};
    end
    assign w_rx_s = r_sync[1];

    // Tick generator, held in IDLE so every frame's ticks are phase-aligned
    // to its own start edge.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || r_state == IDLE || r_clk_cnt == TICK_MAX) r_clk_cnt <= '0;
        else                                                      r_clk_cnt <= r_clk_cnt + 16'd1;
    end
    assign w_tick = (r_state != IDLE) && (r_clk_cnt == TICK_MAX);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state     <= IDLE;
            r_tcnt      <= '0;
            r_bidx      <= '0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_tcnt      <= w_tcnt_nxt;
            r_bidx      <= w_bidx_nxt;
            r_shift     <= w_shift_nxt;
            r_frame_err <= w_stop_bad;
            r_overrun   <= w_push && w_fifo_full;
        end
    end

    always_comb begin
        // NOTE: every output of this block is given a default first, so no
        // path through the case statement can leave one unassigned (latch).
        w_state_nxt = r_state;
        w_tcnt_nxt  = r_tcnt;
        w_bidx_nxt  = r_bidx;
        w_shift_nxt = r_shift;
        w_push      = 1'b0;
        w_stop_bad  = 1'b0;

        case (r_state)
            IDLE: begin
                if (!w_rx_s) begin
                    w_state_nxt = START;
                    w_tcnt_nxt  = '0;
                end
            end

            START: begin
                if (w_tick) begin
                    if (r_tcnt == TCNT_MID) begin
                        // Line back high at mid start bit: glitch, not a frame.
                        if (!w_rx_s) begin
                            w_state_nxt = DATA;
                            w_tcnt_nxt  = '0;
                            w_bidx_nxt  = '0;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end else begin
                        w_tcnt_nxt = r_tcnt + 4'd1;
                    end
                end
            end

            DATA: begin
                if (w_tick) begin
                    if (r_tcnt == TCNT_LAST) begin
                        w_shift_nxt = {w_rx_s, r_shift[7:1]};
                        w_tcnt_nxt  = '0;
                        w_bidx_nxt  = r_bidx + 3'd1;
                        if (r_bidx == BIDX_LAST) w_state_nxt = STOP;
                    end else begin
                        w_tcnt_nxt = r_tcnt + 4'd1;
                    end
                end
            end

            STOP: begin
                if (w_tick) begin
                    if (r_tcnt == TCNT_LAST) begin
                        // Returning to IDLE at mid stop bit leaves half a bit
                        // of slack before a back-to-back start edge.
                        if (w_rx_s) begin
                            w_push      = 1'b1;
                            w_state_nxt = IDLE;
                        end else begin
                            w_stop_bad  = 1'b1;
                            w_state_nxt = WAIT_IDLE;
                        end
                    end else begin
                        w_tcnt_nxt = r_tcnt + 4'd1;
                    end
                end
            end

            WAIT_IDLE: begin
                // A held break produces a single framing error, not one per frame time.
                if (w_rx_s) w_state_nxt = IDLE;
            end

            default: w_state_nxt = IDLE;
        endcase
    end

    io_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (wb_clk_i),
        .i_rst   (wb_rst_i),
        .i_push  (w_push),
        .i_data  (r_shift),
        .i_pop   (m_ready_i),
        .o_data  (m_data_o),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (fifo_count_o)
    );

endmodule : io_uart_rx

// File: tb/tb_io_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_io_uart_rx
// Self-checking bench for io_uart_rx at CLKS_PER_TICK=4, FIFO_DEPTH=8.
// Expected bytes are queued when a good frame is driven and compared when the
// DUT hands a byte over the valid/ready interface.
// -----------------------------------------------------------------------------
module tb_io_uart_rx;

    localparam int CPT     = 4;
    localparam int DEPTH   = 8;
    localparam int BIT_CYC = 16 * CPT;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic       rx_oeb;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic       frame_err;
    logic       overrun;
    logic [3:0] fifo_count;

    int         n_checks = 0;
    int         n_errors = 0;
    int         n_ferr   = 0;
    int         n_ovr    = 0;
    logic [7:0] exp_q[$];
    logic       prev_hold = 1'b0;
    logic [7:0] prev_data = '0;
    logic       toggling  = 1'b0;

    io_uart_rx #(
        .CLKS_PER_TICK (CPT),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .rx_i         (rx),
        .rx_oeb_o     (rx_oeb),
        .m_data_o     (m_data),
        .m_valid_o    (m_valid),
        .m_ready_i    (m_ready),
        .frame_err_o  (frame_err),
        .overrun_o    (overrun),
        .fifo_count_o (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        wait_cycles(BIT_CYC);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_cycles(BIT_CYC);
        end
        rx = stop_bit;
        wait_cycles(BIT_CYC);
    endtask

    task automatic send_good(input logic [7:0] b);
        exp_q.push_back(b);
        send_frame(b, 1'b1);
    endtask

    task automatic drain(input string tag);
        int budget;
        budget  = 400;
        m_ready = 1'b1;
        while (exp_q.size() != 0 && budget > 0) begin
            wait_cycles(1);
            budget--;
        end
        if (budget == 0) check({tag, "_timeout"}, exp_q.size(), 0);
        wait_cycles(2);
        check({tag, "_count"}, fifo_count, 0);
        check({tag, "_valid"}, m_valid, 0);
        m_ready = 1'b0;
        wait_cycles(1);
    endtask

    // Output monitor: pulse counting, hold-stability and scoreboard compare.
    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (frame_err) n_ferr++;
            if (overrun)   n_ovr++;
            if (prev_hold) begin
                check("hold_valid", m_valid, 1);
                check("hold_data", m_data, prev_data);
            end
            if (m_valid && m_ready) begin
                check("sb_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("sb_data", m_data, exp_q.pop_front());
            end
            prev_hold = m_valid && !m_ready;
            prev_data = m_data;
        end
    end

    initial begin
        int ferr0;
        int ovr0;

        // Reset values.
        wait_cycles(3);
        rst = 1'b0;
        check("rst_valid", m_valid, 0);
        check("rst_data", m_data, 0);
        check("rst_count", fifo_count, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_ovr", overrun, 0);
        check("rst_oeb", rx_oeb, 1);
        wait_cycles(5);

        // Single byte, consumer stalled.
        ferr0 = n_ferr; ovr0 = n_ovr;
        send_good(8'hA5);
        wait_cycles(5);
        check("single_valid", m_valid, 1);
        check("single_data", m_data, 8'hA5);
        check("single_count", fifo_count, 1);
        check("single_ferr", n_ferr - ferr0, 0);
        check("single_ovr", n_ovr - ovr0, 0);
        drain("single_drain");

        // False start: low for 20 cycles, under half a bit.
        rx = 1'b0;
        wait_cycles(20);
        rx = 1'b1;
        wait_cycles(3 * BIT_CYC);
        check("false_valid", m_valid, 0);
        check("false_count", fifo_count, 0);
        send_good(8'h5C);
        wait_cycles(5);
        check("false_after_count", fifo_count, 1);
        drain("false_drain");

        // Framing error followed by a held break, then a good byte.
        ferr0 = n_ferr;
        send_frame(8'h3C, 1'b0);
        wait_cycles(3 * BIT_CYC);
        rx = 1'b1;
        wait_cycles(2 * BIT_CYC);
        check("ferr_pulses", n_ferr - ferr0, 1);
        check("ferr_count", fifo_count, 0);
        send_good(8'h81);
        wait_cycles(5);
        check("ferr_next_data", m_data, 8'h81);
        drain("ferr_drain");

        // Overrun: nine bytes into an eight-entry FIFO.
        ovr0 = n_ovr;
        for (int i = 0; i < 9; i++) begin
            if (i < DEPTH) exp_q.push_back(8'(i));
            send_frame(8'(i), 1'b1);
        end
        wait_cycles(5);
        check("ovr_count", fifo_count, DEPTH);
        check("ovr_pulses", n_ovr - ovr0, 1);
        check("ovr_head", m_data, 8'h00);
        drain("ovr_drain");

        // Back-pressure while streaming back-to-back frames.
        toggling = 1'b1;
        fork
            begin
                while (toggling) begin
                    @(posedge clk); #1;
                    m_ready = ~m_ready;
                end
            end
            begin
                send_good(8'h11);
                send_good(8'h22);
                send_good(8'h33);
                wait_cycles(40);
                toggling = 1'b0;
            end
        join
        drain("bp_drain");

        // Reset after data bit 3 of 0xFF.
        rx = 1'b0;
        wait_cycles(BIT_CYC);
        rx = 1'b1;
        wait_cycles(4 * BIT_CYC);
        rst = 1'b1;
        wait_cycles(1);
        rst = 1'b0;
        check("mid_rst_valid", m_valid, 0);
        check("mid_rst_data", m_data, 0);
        check("mid_rst_count", fifo_count, 0);
        check("mid_rst_ferr", frame_err, 0);
        check("mid_rst_ovr", overrun, 0);
        check("mid_rst_oeb", rx_oeb, 1);
        wait_cycles(5 * BIT_CYC);
        check("mid_rst_idle_count", fifo_count, 0);
        send_good(8'h5A);
        wait_cycles(5);
        check("mid_rst_next_data", m_data, 8'h5A);
        drain("mid_rst_drain");

        check("sb_leftover", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_io_uart_rx
